// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler
//   Runs a queue of 2D-convolution jobs on a single conv core. All jobs share one
//   image/result RAM. The host pushes job base addresses into a small FIFO. For each
//   job the scheduler pulses core start, waits for core ready, reports completion,
//   and then pulses core reset so the core is re-armed for the next job. Core RAM
//   addresses are relocated by the base of the current job.
//
// Optional feature: define CONV_SCHED_WDOG_EN to enable the RUN-state watchdog. When
//   the watchdog expires the job completes with done_err_o = 1. With the macro
//   undefined, RUN waits indefinitely and done_err_o is always 0.
//
// Ports
//   clk_i, rst_i              clock; synchronous active-high reset
//   job_valid_i/job_ready_o   host job handshake (job_ready_o = FIFO not full)
//   job_base_i                base address of the offered job
//   core_start_o              1-cycle start pulse to the core
//   core_rst_o                core reset (rst_i or 1-cycle re-arm pulse)
//   core_ready_i              core done flag, sticky until core reset
//   core_raddr_i/core_waddr_i core addresses, relative to the image
//   mem_raddr_o/mem_waddr_o   relocated RAM addresses (wrap modulo 2**AW)
//   done_valid_o              1-cycle completion pulse
//   done_base_o/done_err_o    base and timeout flag of the finished job
//   busy_o                    job in flight or FIFO non-empty
//   jobs_done_o               wrapping count of completed jobs
module conv_job_scheduler #(
    parameter int unsigned AddressBitWidth = 17,
    parameter int unsigned FifoDepthLog2   = 2,
    parameter int unsigned JobCountWidth   = 16,
    parameter int unsigned TimeoutCycles   = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [AddressBitWidth-1:0] job_base_i,
    output logic                       core_start_o,
    output logic                       core_rst_o,
    input  logic                       core_ready_i,
    input  logic [AddressBitWidth-1:0] core_raddr_i,
    input  logic [AddressBitWidth-1:0] core_waddr_i,
    output logic [AddressBitWidth-1:0] mem_raddr_o,
    output logic [AddressBitWidth-1:0] mem_waddr_o,
    output logic                       done_valid_o,
    output logic [AddressBitWidth-1:0] done_base_o,
    output logic                       done_err_o,
    output logic                       busy_o,
    output logic [JobCountWidth-1:0]   jobs_done_o
);

    localparam int unsigned FifoDepth = 2 ** FifoDepthLog2;
    localparam int unsigned CountW    = FifoDepthLog2 + 1;

    typedef enum logic [2:0] {
        StIdle,
        StKick,
        StRun,
        StDone,
        StRecover
    } state_e;

    // Job FIFO
    logic [AddressBitWidth-1:0] fifo_mem_q [FifoDepth];
    logic [FifoDepthLog2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CountW-1:0]          count_q;
    logic                       fifo_full, fifo_empty, push, pop;

    // Scheduler state and registered outputs
    state_e                     state_q, state_d;
    logic [AddressBitWidth-1:0] cur_base_q, cur_base_d;
    logic                       core_start_q, core_start_d;
    logic                       rec_q, rec_d;
    logic                       done_valid_q, done_valid_d;
    logic [AddressBitWidth-1:0] done_base_q, done_base_d;
    logic                       done_err_q, done_err_d;
    logic [JobCountWidth-1:0]   jobs_done_q, jobs_done_d;

`ifdef CONV_SCHED_WDOG_EN
    localparam int unsigned WdogW = $clog2(TimeoutCycles + 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
    logic             wdog_expired;
    assign wdog_expired = (wdog_q == WdogW'(TimeoutCycles - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TimeoutCycles);
`endif

    assign fifo_full   = (count_q == CountW'(FifoDepth));
    assign fifo_empty  = (count_q == '0);
    assign job_ready_o = !fifo_full;
    assign push        = job_valid_i && !fifo_full;

    // FIFO storage: no reset needed, only read below the count
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= job_base_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FifoDepthLog2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FifoDepthLog2'(1);
            if (push && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CountW'(1);
            end
        end
    end

    // State register and registered pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cur_base_q   <= '0;
            core_start_q <= 1'b0;
            rec_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_base_q  <= '0;
            done_err_q   <= 1'b0;
            jobs_done_q  <= '0;
`ifdef CONV_SCHED_WDOG_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cur_base_q   <= cur_base_d;
            core_start_q <= core_start_d;
            rec_q        <= rec_d;
            done_valid_q <= done_valid_d;
            done_base_q  <= done_base_d;
            done_err_q   <= done_err_d;
            jobs_done_q  <= jobs_done_d;
`ifdef CONV_SCHED_WDOG_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    // Next state. Pulses are decoded from the current state and then registered,
    // so each one is seen in the cycle after its state (start lands in first RUN cycle).
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        cur_base_d   = cur_base_q;
        core_start_d = 1'b0;
        rec_d        = 1'b0;
        done_valid_d = 1'b0;
        done_base_d  = done_base_q;
        done_err_d   = done_err_q;
        jobs_done_d  = jobs_done_q;
`ifdef CONV_SCHED_WDOG_EN
        wdog_d       = wdog_q;
        err_d        = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cur_base_d = fifo_mem_q[rd_ptr_q];
                    state_d    = StKick;
`ifdef CONV_SCHED_WDOG_EN
                    err_d      = 1'b0;
`endif
                end
            end
            StKick: begin
                core_start_d = 1'b1;
                state_d      = StRun;
`ifdef CONV_SCHED_WDOG_EN
                wdog_d       = '0;
`endif
            end
            StRun: begin
                if (core_ready_i) begin
                    state_d = StDone;
                end
`ifdef CONV_SCHED_WDOG_EN
                else if (wdog_expired) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
`endif
            end
            StDone: begin
                done_valid_d = 1'b1;
                done_base_d  = cur_base_q;
`ifdef CONV_SCHED_WDOG_EN
                done_err_d   = err_q;
`else
                done_err_d   = 1'b0;
`endif
                jobs_done_d  = jobs_done_q + JobCountWidth'(1);
                state_d      = StRecover;
            end
            StRecover: begin
                // Re-arm the core so a sticky ready cannot retrigger the next job
                rec_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign core_start_o = core_start_q;
    assign core_rst_o   = rst_i | rec_q;
    assign done_valid_o = done_valid_q;
    assign done_base_o  = done_base_q;
    assign done_err_o   = done_err_q;
    assign jobs_done_o  = jobs_done_q;
    assign busy_o       = (state_q != StIdle) || !fifo_empty;

    // Address relocation; carry out of the MSB is dropped
    assign mem_raddr_o = cur_base_q + core_raddr_i;
    assign mem_waddr_o = cur_base_q + core_waddr_i;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Testbench for conv_job_scheduler.
module tb_conv_job_scheduler;

    localparam int unsigned AW  = 17;
    localparam int unsigned JCW = 16;
    localparam int unsigned TO  = 16;

    logic           clk;
    logic           rst;
    logic           job_valid, job_ready;
    logic [AW-1:0]  job_base;
    logic           core_start, core_rst, core_ready;
    logic [AW-1:0]  core_raddr, core_waddr, mem_raddr, mem_waddr;
    logic           done_valid, done_err, busy;
    logic [AW-1:0]  done_base;
    logic [JCW-1:0] jobs_done;

    conv_job_scheduler #(
        .AddressBitWidth(AW),
        .FifoDepthLog2  (2),
        .JobCountWidth  (JCW),
        .TimeoutCycles  (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .job_valid_i (job_valid),
        .job_ready_o (job_ready),
        .job_base_i  (job_base),
        .core_start_o(core_start),
        .core_rst_o  (core_rst),
        .core_ready_i(core_ready),
        .core_raddr_i(core_raddr),
        .core_waddr_i(core_waddr),
        .mem_raddr_o (mem_raddr),
        .mem_waddr_o (mem_waddr),
        .done_valid_o(done_valid),
        .done_base_o (done_base),
        .done_err_o  (done_err),
        .busy_o      (busy),
        .jobs_done_o (jobs_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    // Conv core model: ready rises core_delay cycles after the start pulse and stays
    // high until core reset.
    int core_delay = 10;
    bit rand_delay = 0;
    bit core_never = 0;
    int core_cnt;
    int cur_delay;
    bit core_running;
    always @(posedge clk) begin
        if (core_rst) begin
            core_ready   <= 1'b0;
            core_running <= 1'b0;
            core_cnt     <= 0;
        end else if (core_start) begin
            core_running <= 1'b1;
            core_cnt     <= 1;
            cur_delay    <= rand_delay ? int'($urandom_range(2, 20)) : core_delay;
        end else if (core_running && !core_never) begin
            if (core_cnt >= cur_delay - 1) begin
                core_ready   <= 1'b1;
                core_running <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [AW-1:0]  base;
        logic           err;
        logic [JCW-1:0] jd;
        int             cyc;
    } done_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [AW-1:0] mr;
        logic [AW-1:0] mw;
    } addr_t;

    done_t         done_q[$];
    addr_t         addr_q[$];
    int            start_q[$];
    int            crst_q[$];
    logic [AW-1:0] send_q[$];
    logic [AW-1:0] acc_q[$];
    int            acc_cyc[$];
    int            n_started;
    logic [AW-1:0] run_base;
    bit            running_m;
    bit            fixed_addr = 0;
    logic [AW-1:0] fix_ra, fix_wa;

    task automatic clear_tb();
        done_q.delete(); addr_q.delete(); start_q.delete(); crst_q.delete();
        acc_q.delete(); acc_cyc.delete();
        n_started = 0;
        running_m = 1'b0;
    endtask

    // One clock: drive inputs, observe at negedge, record events and acceptances
    task automatic step();
        done_t d;
        addr_t a;
        bit    acc;
        job_valid = (send_q.size() > 0);
        job_base  = (send_q.size() > 0) ? send_q[0] : '0;
        if (fixed_addr) begin
            core_raddr = fix_ra;
            core_waddr = fix_wa;
        end else begin
            core_raddr = AW'($urandom);
            core_waddr = AW'($urandom);
        end
        @(negedge clk);
        if (core_start && !rst) begin
            start_q.push_back(cyc);
            if (n_started < acc_q.size()) run_base = acc_q[n_started];
            n_started++;
            running_m = 1'b1;
        end
        if (running_m && !rst) begin
            a.base = run_base; a.ra = core_raddr; a.wa = core_waddr;
            a.mr = mem_raddr;  a.mw = mem_waddr;
            addr_q.push_back(a);
        end
        if (done_valid) begin
            d.base = done_base; d.err = done_err; d.jd = jobs_done; d.cyc = cyc;
            done_q.push_back(d);
            running_m = 1'b0;
        end
        if (core_rst && !rst) crst_q.push_back(cyc);
        acc = job_valid && job_ready && !rst;
        @(posedge clk);
        #1;
        if (acc) begin
            acc_q.push_back(send_q.pop_front());
            acc_cyc.push_back(cyc);
        end
    endtask

    task automatic apply_reset();
        send_q.delete();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_tb();
    endtask

    task automatic run_until_done(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic test_reset();
        logic [20:0] obs, exp;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {core_rst, job_ready, busy, done_valid, core_start, jobs_done};
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_state cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        rst = 1'b0;
        clear_tb();
        step();
        vectors++;
        if ({core_rst, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: core_rst,busy got %b expected 00", {core_rst, busy});
        end
    endtask

    task automatic test_single_job();
        apply_reset();
        core_delay = 40;
        send_q.push_back(17'h00100);
        run_until_done(1, 300);
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (done_q.size() != 1 || start_q.size() != 1 || crst_q.size() != 1) begin
            miscompares++;
            $display("FAIL single_counts: done %0d start %0d core_rst %0d expected 1 1 1",
                     done_q.size(), start_q.size(), crst_q.size());
        end
        if (done_q.size() == 1 && start_q.size() == 1 && crst_q.size() == 1 && acc_cyc.size() == 1) begin
            vectors++;
            if (start_q[0] != acc_cyc[0] + 2) begin
                miscompares++;
                $display("FAIL single_start_latency: got %0d expected %0d", start_q[0] - acc_cyc[0], 2);
            end
            vectors++;
            if (done_q[0].cyc != start_q[0] + 42) begin
                miscompares++;
                $display("FAIL single_done_time: got +%0d expected +42", done_q[0].cyc - start_q[0]);
            end
            vectors++;
            if ({done_q[0].base, done_q[0].err, done_q[0].jd} !== {17'h00100, 1'b0, 16'd1}) begin
                miscompares++;
                $display("FAIL single_done: base %h err %b jd %0d expected 00100 0 1",
                         done_q[0].base, done_q[0].err, done_q[0].jd);
            end
            vectors++;
            if (crst_q[0] != done_q[0].cyc + 1) begin
                miscompares++;
                $display("FAIL single_core_rst: got +%0d expected +1", crst_q[0] - done_q[0].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        core_delay = 30;
        for (int i = 0; i < 5; i++) send_q.push_back(AW'(17'h01000 + i * 17'h00400));
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (acc_q.size() != 5 || job_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_fill: accepted %0d ready %b expected 5 0", acc_q.size(), job_ready);
        end
        run_until_done(5, 800);
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (done_q.size() != 5 || start_q.size() != 5 || jobs_done !== 16'd5) begin
            miscompares++;
            $display("FAIL b2b_counts: done %0d start %0d jobs_done %0d expected 5 5 5",
                     done_q.size(), start_q.size(), jobs_done);
        end
        for (int i = 0; i < done_q.size() && i < acc_q.size(); i++) begin
            vectors++;
            if ({done_q[i].base, done_q[i].err, done_q[i].jd} !== {acc_q[i], 1'b0, JCW'(i + 1)}) begin
                miscompares++;
                $display("FAIL b2b_done[%0d]: base %h err %b jd %0d expected %h 0 %0d",
                         i, done_q[i].base, done_q[i].err, done_q[i].jd, acc_q[i], i + 1);
            end
        end
        for (int i = 1; i < done_q.size() && i < start_q.size(); i++) begin
            vectors++;
            if (start_q[i] != done_q[i-1].cyc + 3) begin
                miscompares++;
                $display("FAIL b2b_restart[%0d]: got +%0d expected +3", i, start_q[i] - done_q[i-1].cyc);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        core_delay = 50;
        fixed_addr = 1'b1;
        fix_ra = 17'h00002;
        fix_wa = 17'h00000;
        send_q.push_back(17'h1FFFF);
        run_until_done(1, 200);
        fixed_addr = 1'b0;
        vectors++;
        if (addr_q.size() == 0 || done_q.size() != 1) begin
            miscompares++;
            $display("FAIL wrap_activity: addr samples %0d done %0d expected >0 1", addr_q.size(), done_q.size());
        end
        foreach (addr_q[i]) begin
            vectors++;
            if ({addr_q[i].mr, addr_q[i].mw} !== {17'h00001, 17'h1FFFF}) begin
                miscompares++;
                $display("FAIL wrap_addr: raddr %h waddr %h expected 00001 1ffff", addr_q[i].mr, addr_q[i].mw);
            end
        end
    endtask

    task automatic test_random();
        int          pushed = 0;
        int          k = 0;
        int unsigned sr, sw;
        apply_reset();
        rand_delay = 1'b1;
        while (done_q.size() < 24 && k < 4000) begin
            if (pushed < 24 && $urandom_range(0, 2) == 0) begin
                send_q.push_back(AW'($urandom));
                pushed++;
            end
            step();
            k++;
        end
        rand_delay = 1'b0;
        vectors++;
        if (done_q.size() != 24 || jobs_done !== 16'd24) begin
            miscompares++;
            $display("FAIL rand_count: done %0d jobs_done %0d expected 24 24", done_q.size(), jobs_done);
        end
        for (int i = 0; i < done_q.size() && i < acc_q.size(); i++) begin
            vectors++;
            if ({done_q[i].base, done_q[i].err, done_q[i].jd} !== {acc_q[i], 1'b0, JCW'(i + 1)}) begin
                miscompares++;
                $display("FAIL rand_done[%0d]: base %h err %b jd %0d expected %h 0 %0d",
                         i, done_q[i].base, done_q[i].err, done_q[i].jd, acc_q[i], i + 1);
            end
        end
        foreach (addr_q[i]) begin
            sr = 32'(addr_q[i].base) + 32'(addr_q[i].ra);
            sw = 32'(addr_q[i].base) + 32'(addr_q[i].wa);
            sr = sr % 32'h20000;
            sw = sw % 32'h20000;
            vectors++;
            if ({addr_q[i].mr, addr_q[i].mw} !== {AW'(sr), AW'(sw)}) begin
                miscompares++;
                $display("FAIL rand_addr[%0d]: raddr %h waddr %h expected %h %h",
                         i, addr_q[i].mr, addr_q[i].mw, AW'(sr), AW'(sw));
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int k = 0;
        logic [18:0] obs;
        apply_reset();
        core_delay = 10;
        send_q.push_back(17'h00AAA);
        run_until_done(1, 100);
        core_delay = 200;
        send_q.push_back(17'h00200);
        send_q.push_back(17'h00300);
        send_q.push_back(17'h00400);
        while (start_q.size() < 2 && k < 100) begin
            step();
            k++;
        end
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (acc_q.size() != 4 || busy !== 1'b1 || jobs_done !== 16'd1) begin
            miscompares++;
            $display("FAIL midrst_setup: accepted %0d busy %b jobs_done %0d expected 4 1 1",
                     acc_q.size(), busy, jobs_done);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {core_rst, job_ready, busy, jobs_done};
            vectors++;
            if (obs !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
                miscompares++;
                $display("FAIL midrst_state: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 16'h0000});
            end
        end
        rst = 1'b0;
        clear_tb();
        for (int i = 0; i < 100; i++) step();
        vectors++;
        if (done_q.size() != 0 || start_q.size() != 0 || crst_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet: done %0d start %0d core_rst %0d busy %b expected 0 0 0 0",
                     done_q.size(), start_q.size(), crst_q.size(), busy);
        end
    endtask

`ifdef CONV_SCHED_WDOG_EN
    task automatic test_watchdog();
        apply_reset();
        core_never = 1'b1;
        send_q.push_back(17'h00500);
        run_until_done(1, 100);
        core_never = 1'b0;
        core_delay = 5;
        send_q.push_back(17'h00600);
        run_until_done(2, 100);
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (done_q.size() != 2 || start_q.size() != 2) begin
            miscompares++;
            $display("FAIL wdog_counts: done %0d start %0d expected 2 2", done_q.size(), start_q.size());
        end
        if (done_q.size() == 2 && start_q.size() == 2) begin
            vectors++;
            if ({done_q[0].base, done_q[0].err} !== {17'h00500, 1'b1} || done_q[0].cyc != start_q[0] + TO + 1) begin
                miscompares++;
                $display("FAIL wdog_timeout: base %h err %b at +%0d expected 00500 1 +%0d",
                         done_q[0].base, done_q[0].err, done_q[0].cyc - start_q[0], TO + 1);
            end
            vectors++;
            if ({done_q[1].base, done_q[1].err} !== {17'h00600, 1'b0} || start_q[1] != done_q[0].cyc + 3) begin
                miscompares++;
                $display("FAIL wdog_next: base %h err %b restart +%0d expected 00600 0 +3",
                         done_q[1].base, done_q[1].err, start_q[1] - done_q[0].cyc);
            end
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_base   = '0;
        core_raddr = '0;
        core_waddr = '0;
        fix_ra     = '0;
        fix_wa     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid_job();
`ifdef CONV_SCHED_WDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
